// File: rtl/hpf_self_trigger.sv
// hpf_self_trigger: per-channel rising-threshold self-trigger for the 40
// filtered channels of the pedestal-recovery filter output bus.
//
// Per-channel FSM:
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | disabled; waiting for en
//   ST_WAIT_LOW | enabled; waiting for a sample below threshold
//   ST_ARMED    | seen a low sample; next sample >= threshold fires
//   ST_HOLDOFF  | dead time after a trigger; hold_q counts down to 0
module hpf_self_trigger #(
  parameter int unsigned HOLDOFF = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [719:0] x,
  input  logic [15:0]  threshold,
  input  logic         count_clr,
  output logic [39:0]  trig,
  output logic         trig_any,
  output logic [31:0]  event_count
);

  localparam int          NCH       = 40;
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LOW,
    ST_ARMED,
    ST_HOLDOFF
  } state_t;

  logic [719:0]       x_q;
  logic signed [15:0] thr_q;
  logic signed [15:0] samp [NCH];
  logic [15:0]        slot8_unused;
  state_t             state_q [NCH];
  logic [15:0]        hold_q [NCH];
  logic [NCH-1:0]     fire_d;
  logic [NCH-1:0]     trig_q;
  logic               trig_any_q;
  logic [31:0]        event_count_q;

  // Register the sample bus every cycle; capture the threshold only while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      thr_q <= '0;
    end else begin
      x_q <= x;
      if (!en) thr_q <= threshold;
    end
  end

  // Extract the 40 filtered channels; slot 8 of each AFE is the unfiltered passthrough.
  always_comb begin
    slot8_unused = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 8; j++) begin
        samp[i*8+j] = x_q[(i*9+j)*16 +: 16];
      end
      slot8_unused = slot8_unused ^ x_q[(i*9+8)*16 +: 16];
    end
  end

  // Trigger decision: armed channel at or above threshold, never while disabled.
  always_comb begin
    fire_d = '0;
    for (int k = 0; k < NCH; k++) begin
      fire_d[k] = en && (state_q[k] == ST_ARMED) && (samp[k] >= thr_q);
    end
  end

  // Per-channel FSMs with registered trigger outputs; en low forces IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= ST_IDLE;
        hold_q[k]  <= '0;
      end
      trig_q     <= '0;
      trig_any_q <= 1'b0;
    end else begin
      trig_q     <= fire_d;
      trig_any_q <= |fire_d;
      for (int k = 0; k < NCH; k++) begin
        if (!en) begin
          state_q[k] <= ST_IDLE;
          hold_q[k]  <= '0;
        end else begin
          case (state_q[k])
            ST_IDLE:     state_q[k] <= ST_WAIT_LOW;
            ST_WAIT_LOW: if (samp[k] < thr_q) state_q[k] <= ST_ARMED;
            ST_ARMED: begin
              if (fire_d[k]) begin
                hold_q[k]  <= HOLD_LOAD;
                state_q[k] <= ST_HOLDOFF;
              end
            end
            ST_HOLDOFF: begin
              if (hold_q[k] == 16'd0) state_q[k] <= ST_WAIT_LOW;
              else                    hold_q[k]  <= hold_q[k] - 16'd1;
            end
            default: state_q[k] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Saturating count of trigger cycles; a clear wins over an increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_count_q <= '0;
    end else if (count_clr) begin
      event_count_q <= '0;
    end else if (trig_any_q && (event_count_q != 32'hFFFF_FFFF)) begin
      event_count_q <= event_count_q + 32'd1;
    end
  end

  assign trig        = trig_q;
  assign trig_any    = trig_any_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_hpf_self_trigger.sv
// Bench for hpf_self_trigger: directed scenarios plus random traffic, all
// checked against a timeline-style reference model of the channel rules.
module tb_hpf_self_trigger;

  localparam int HOLDOFF = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [719:0] x;
  logic [15:0]  threshold;
  logic         count_clr;
  logic [39:0]  trig;
  logic         trig_any;
  logic [31:0]  event_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [719:0]       xq_m;
  logic signed [15:0] thr_m;
  int                 low_ok_from [40];
  bit                 low_seen [40];
  logic [39:0]        trig_m;
  logic               any_m;
  logic [31:0]        cnt_m;
  int                 edge_n;

  always #5 clk = ~clk;

  hpf_self_trigger #(.HOLDOFF(HOLDOFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .x           (x),
    .threshold   (threshold),
    .count_clr   (count_clr),
    .trig        (trig),
    .trig_any    (trig_any),
    .event_count (event_count)
  );

  function automatic int slot_base(int k);
    return ((k / 8) * 9 + (k % 8)) * 16;
  endfunction

  task automatic set_ch(input int k, input logic [15:0] v);
    x[slot_base(k) +: 16] = v;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int k = 0; k < 40; k++) set_ch(k, v);
  endtask

  task automatic model_reset();
    xq_m   = '0;
    thr_m  = '0;
    trig_m = '0;
    any_m  = 1'b0;
    cnt_m  = '0;
    edge_n = 0;
    for (int k = 0; k < 40; k++) begin
      low_ok_from[k] = 1;
      low_seen[k]    = 1'b0;
    end
  endtask

  // One clock edge of the model. A channel fires when it has seen a qualifying
  // low sample and now sees one at or above threshold; after a fire no low sample
  // counts until HOLDOFF+1 edges later; a disabled edge forgets everything and
  // low samples count again two edges after it.
  task automatic model_edge();
    logic [39:0]        nt;
    logic signed [15:0] s;
    nt = '0;
    for (int k = 0; k < 40; k++) begin
      s = xq_m[slot_base(k) +: 16];
      if (!en) begin
        low_ok_from[k] = edge_n + 2;
        low_seen[k]    = 1'b0;
      end else if (low_seen[k] && s >= thr_m) begin
        nt[k]          = 1'b1;
        low_ok_from[k] = edge_n + 1 + HOLDOFF;
        low_seen[k]    = 1'b0;
      end else if (!low_seen[k] && edge_n >= low_ok_from[k] && s < thr_m) begin
        low_seen[k] = 1'b1;
      end
    end
    if (count_clr)                         cnt_m = '0;
    else if (any_m && cnt_m != '1)         cnt_m = cnt_m + 32'd1;
    any_m  = |nt;
    trig_m = nt;
    if (!en) thr_m = threshold;
    xq_m   = x;
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    en        = 1'b1;
    count_clr = 1'b0;
    threshold = 16'd0;
    for (int k = 0; k < 45; k++) x[k*16 +: 16] = 16'($urandom);
    reset = 1'b1;
    #2;
    n_vec++;
    if (trig !== 40'h0 || trig_any !== 1'b0 || event_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_held trig=%h any=%b cnt=%h expected 0/0/0", trig, trig_any, event_count);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (trig !== 40'h0 || trig_any !== 1'b0 || event_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_held_edges trig=%h any=%b cnt=%h expected 0/0/0", trig, trig_any, event_count);
    end
    reset = 1'b0;
    model_reset();
    tick();
    n_vec++;
    if (trig !== 40'h0 || trig_any !== 1'b0 || event_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release trig=%h any=%b cnt=%h expected 0/0/0", trig, trig_any, event_count);
    end
  endtask

  task automatic test_single_crossing();
    en = 1'b0; count_clr = 1'b1; threshold = 16'd100; set_all(16'd0);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin en = 1'b1; count_clr = 1'b0; end
      if (c == 5) set_ch(5, 16'd200);
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL single_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      if (c == 6) begin
        n_vec++;
        if (trig !== 40'h20 || trig_any !== 1'b1) begin
          n_err++;
          $display("FAIL single_pulse trig=%h any=%b expected 0000000020/1", trig, trig_any);
        end
      end
      if (c == 5 || c == 7) begin
        n_vec++;
        if (trig !== 40'h0 || trig_any !== 1'b0) begin
          n_err++;
          $display("FAIL single_width c=%0d trig=%h any=%b expected 0/0", c, trig, trig_any);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (event_count !== 32'd1) begin
          n_err++;
          $display("FAIL single_count cnt=%h expected 1", event_count);
        end
      end
    end
  endtask

  task automatic test_holdoff();
    for (int c = 0; c < 90; c++) begin
      if (c == 0)  set_ch(5, 16'd0);
      if (c == 10) set_ch(5, 16'd200);
      if (c == 13) set_ch(5, 16'd0);
      if (c == 83) set_ch(5, 16'd200);
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL holdoff_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      n_vec++;
      if (trig[5] !== (c == 84)) begin
        n_err++;
        $display("FAIL holdoff_pulse c=%0d trig5=%b expected %b", c, trig[5], (c == 84));
      end
    end
  endtask

  task automatic test_slot_and_simul();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) x[(2*9+8)*16 +: 16] = 16'h7FFF;
      if (c == 5) begin set_ch(0, 16'd200); set_ch(39, 16'd200); end
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL simul_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      if (c < 6) begin
        n_vec++;
        if (trig !== 40'h0) begin
          n_err++;
          $display("FAIL ignored_slot c=%0d trig=%h expected 0", c, trig);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (trig !== 40'h80_0000_0001 || trig_any !== 1'b1) begin
          n_err++;
          $display("FAIL simul_pulse trig=%h any=%b expected 8000000001/1", trig, trig_any);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (event_count !== 32'd3) begin
          n_err++;
          $display("FAIL simul_count cnt=%h expected 3", event_count);
        end
      end
    end
  endtask

  task automatic test_signed_enable();
    for (int c = 0; c < 96; c++) begin
      if (c == 0) begin en = 1'b0; threshold = 16'hFFCE; set_all(16'hFF9C); end
      if (c == 2) en = 1'b1;
      if (c == 7) begin set_ch(12, 16'hFFD8); set_ch(20, 16'h8000); end
      if (c == 12) begin en = 1'b0; set_ch(12, 16'hFF9C); end
      if (c == 14) en = 1'b1;
      if (c == 15) set_ch(12, 16'hFFD8);
      if (c == 20) begin threshold = 16'd1000; set_ch(12, 16'hFF9C); end
      if (c == 90) set_ch(12, 16'd0);
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL signed_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      n_vec++;
      if (trig[12] !== (c == 8 || c == 16 || c == 91) || trig[20] !== 1'b0) begin
        n_err++;
        $display("FAIL signed_pulse c=%0d trig12=%b trig20=%b expected %b/0",
                 c, trig[12], trig[20], (c == 8 || c == 16 || c == 91));
      end
    end
  endtask

  task automatic test_reset_in_holdoff();
    reset = 1'b1;
    #2;
    n_vec++;
    if (trig !== 40'h0 || trig_any !== 1'b0 || event_count !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset trig=%h any=%b cnt=%h expected 0/0/0", trig, trig_any, event_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 80; c++) begin
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL post_reset_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      n_vec++;
      if (trig !== 40'h0 || event_count !== 32'h0) begin
        n_err++;
        $display("FAIL post_reset_residual c=%0d trig=%h cnt=%h expected 0/0", c, trig, event_count);
      end
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 18; c++) begin
      if (c == 0) begin en = 1'b0; threshold = 16'd100; set_all(16'd0); count_clr = 1'b0; end
      if (c == 2) en = 1'b1;
      if (c == 6) begin
        force dut.event_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.event_count_q;
        cnt_m = 32'hFFFF_FFFE;
        set_ch(0, 16'd200);
      end
      if (c == 7)  set_ch(1, 16'd200);
      if (c == 8)  set_ch(2, 16'd200);
      if (c == 12) set_ch(3, 16'd200);
      if (c == 13) set_ch(4, 16'd200);
      if (c == 14) count_clr = 1'b1;
      if (c == 15) count_clr = 1'b0;
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL sat_model c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
      if (c == 10 || c == 12) begin
        n_vec++;
        if (event_count !== 32'hFFFF_FFFF) begin
          n_err++;
          $display("FAIL sat_hold c=%0d cnt=%h expected ffffffff", c, event_count);
        end
      end
      if (c == 14) begin
        n_vec++;
        if (event_count !== 32'h0 || trig_any !== 1'b1) begin
          n_err++;
          $display("FAIL clr_priority cnt=%h any=%b expected 0/1", event_count, trig_any);
        end
      end
      if (c == 15) begin
        n_vec++;
        if (event_count !== 32'd1) begin
          n_err++;
          $display("FAIL clr_then_count cnt=%h expected 1", event_count);
        end
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) begin
        v = int'($urandom_range(0, 600)) - 300;
        threshold = v[15:0];
      end
      count_clr = ($urandom_range(0, 99) == 0);
      for (int s = 0; s < 45; s++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 9))
            0:       v = 32'h0000_8000;
            1:       v = 32'h0000_7FFF;
            default: v = int'($urandom_range(0, 600)) - 300;
          endcase
          x[s*16 +: 16] = v[15:0];
        end
      end
      tick();
      n_vec++;
      if (trig !== trig_m || trig_any !== any_m || event_count !== cnt_m) begin
        n_err++;
        $display("FAIL random c=%0d trig=%h exp %h any=%b exp %b cnt=%h exp %h",
                 c, trig, trig_m, trig_any, any_m, event_count, cnt_m);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    x         = '0;
    threshold = '0;
    count_clr = 1'b0;
    test_reset();
    test_single_crossing();
    test_holdoff();
    test_slot_and_simul();
    test_signed_enable();
    test_reset_in_holdoff();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hpf_self_trigger.md
# hpf_self_trigger

Per-channel self-trigger stage that sits directly downstream of `hpf_pedestal_recovery_filter` and consumes its 720-bit filtered sample bus. It covers 5 AFEs × 8 filtered channels, 40 channels in total, and ignores slot 8 of each AFE, which is an unfiltered passthrough. For each channel it detects a rising threshold crossing with re-arm and holdoff logic, emits a one-cycle trigger pulse per channel, and keeps a global saturating event counter for the readout/control logic.

## Interface
Parameters:
- `HOLDOFF`, default 64: dead time in clock cycles after a trigger, before a channel may re-arm. Legal range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic is in this single domain.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `en`  in  1  trigger enable. It tracks the same `en` that the filter sees.
- `x`  in  720  filtered sample bus, signed 16-bit two's complement.
  - Channel k = i*8+j, with i=0..4 and j=0..7, occupies `x[(i*9+j)*16 +: 16]`.
  - Slots `(i*9+8)` are ignored.
- `threshold`  in  16  signed trigger threshold. It is latched only while `en`=0.
- `count_clr`  in  1  synchronous clear of `event_count`.
- `trig`  out  40  per-channel one-cycle trigger pulse; bit k corresponds to channel k.
- `trig_any`  out  1  registered OR of the 40 per-channel trigger decisions; asserted in the same cycle as `trig`.
- `event_count`  out  32  count of cycles in which `trig_any` was asserted. Saturating.

## Operation
- Stage 1 (sample register): `x_q` is registered from `x` every cycle, regardless of `en`.
- Threshold register:
  - `thr_q` loads `threshold` on every edge where `en`=0.
  - `thr_q` holds its value while `en`=1.
- Per-channel state machine: IDLE, WAIT_LOW, ARMED, HOLDOFF.
  - IDLE: if `en`=1, go to WAIT_LOW.
  - WAIT_LOW: if `s < thr_q`, go to ARMED. This prevents a trigger on a channel that is already above threshold when enabled.
  - ARMED: if `s >= thr_q`:
    - assert that channel's trigger;
    - load the holdoff counter with `HOLDOFF-1`;
    - go to HOLDOFF.
  - HOLDOFF:
    - decrement the counter each cycle;
    - when the counter reaches 0, go to WAIT_LOW;
    - no trigger is possible in this state.
  - Any state: if `en`=0, go to IDLE and clear the counter. This takes priority over every other transition.
- Comparisons are signed 16-bit. `s` is the channel's `x_q` slice. `0x8000` is -32768. There is no widening and no arithmetic on samples.
- `event_count`:
  - increments by exactly 1 per cycle in which `trig_any`=1, however many channels fired;
  - saturates at `0xFFFFFFFF`;
  - `count_clr` has priority over an increment in the same cycle; the result is 0.
- Reset values:
  - `trig`=0, `trig_any`=0, `event_count`=0;
  - all channels in IDLE with counters at 0;
  - `x_q`=0, `thr_q`=0.

## Timing
- Latency: a sample presented on `x` before edge n appears in `x_q` after edge n. A crossing is then reflected on `trig`/`trig_any` after edge n+1, i.e. 2 clocks from the input.
- `event_count` reflects a pulse one edge after `trig_any` (edge n+2).
- `trig[k]` is high for exactly one cycle per crossing.
- Minimum spacing between two triggers on one channel is `HOLDOFF`+2 cycles:
  - `HOLDOFF` cycles in HOLDOFF;
  - at least one cycle in WAIT_LOW with `s < thr_q`;
  - one cycle in ARMED.
- `en` deassert:
  - channels are in IDLE after the next edge;
  - a trigger decided on that same edge is suppressed, so `trig`=0 from that edge onward.
- `en` assert: the earliest possible trigger is 3 edges later (IDLE → WAIT_LOW → ARMED → trigger).
- An asynchronous `reset` asserted mid-HOLDOFF returns to reset values immediately, with no residual pulse after release.

## Test plan
- Reset check: assert `reset` with arbitrary `x`, `en`=1 → `trig`=0, `trig_any`=0 and `event_count`=0 while reset is held and on the first cycle after release.
- Single crossing:
  - setup: `threshold`=100 latched with `en`=0, then `en`=1, all channels at 0;
  - stimulus: channel 5 (slot i=0, j=5) steps to 200 at cycle t;
  - response: `trig`=`40'h20` and `trig_any`=1 only in cycle t+2, then `event_count`=1.
- Holdoff/re-arm (`HOLDOFF`=64):
  - sequence on channel 5: 200, then 0 for 10 cycles, then 200 → no second pulse;
  - stay at 0 past 64 holdoff cycles, then step to 200 → second pulse exactly 2 cycles after that step.
- Ignored slot and simultaneity:
  - slot 8 of AFE 2 driven to 32767 → no trigger;
  - channels 0 and 39 cross in the same cycle → `trig`=`40'h80_0000_0001`, `event_count` increments by 1.
- Signed and enable abort:
  - `threshold`=-50, channel 12 goes -100 → -40 → triggers;
  - `0x8000` input → no trigger;
  - deassert `en` mid-HOLDOFF, reassert → 3-edge re-arm delay;
  - `threshold` changed while `en`=1 is ignored.
- Counter limits: force 2^32-1 trigger cycles (counter preset via a long run or a bench shortcut) → `event_count` holds at `0xFFFFFFFF`; `count_clr` together with a trigger → 0.
